// File: rtl/mem_block_mover.sv
// Block copy / fill bus master for the shared data memory.
// Latency: copy 2*Len busy cycles, fill Len busy cycles, then one Done cycle.
// No backpressure: the memory answers combinationally, Start is ignored unless idle.
//
// Ports:
//   CLK, Reset                 clock, asynchronous active-high reset
//   Start, Mode                request pulse; 0 = copy, 1 = fill
//   SrcAddr, DstAddr, Len      block parameters (Len = byte count, 0 allowed)
//   FillVal                    fill constant
//   Busy, Done, Checksum       status; Busy doubles as the memory grant request
//   MemAddr, MemRead,
//   MemWrite, MemWrData        memory master port
//   MemRdData                  combinational read data from memory
module mem_block_mover #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Mode,
    input  logic [AW-1:0] SrcAddr,
    input  logic [AW-1:0] DstAddr,
    input  logic [AW-1:0] Len,
    input  logic [DW-1:0] FillVal,
    output logic          Busy,
    output logic          Done,
    output logic [DW-1:0] Checksum,
    output logic [AW-1:0] MemAddr,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [DW-1:0] MemWrData,
    input  logic [DW-1:0] MemRdData
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state;
    state_t        stateNext;

    // The operating mode is captured by the choice of RD vs FILL, so it needs
    // no register of its own.
    logic [AW-1:0] srcReg;
    logic [AW-1:0] dstReg;
    logic [AW-1:0] lenReg;
    logic [DW-1:0] fillReg;
    logic [AW-1:0] idx;
    logic [DW-1:0] holdReg;
    logic [DW-1:0] checksumReg;

    logic [AW-1:0] idxNext;
    logic          lastByte;
    logic          startAccept;

    assign idxNext     = idx + AW'(1);
    // Len <= 2^AW-1, so idx+1 never wraps before matching.
    assign lastByte    = (idxNext == lenReg);
    assign startAccept = (state == IDLE) && Start;

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Len == '0) begin
                        stateNext = DONE;
                    end else if (Mode) begin
                        stateNext = FILL;
                    end else begin
                        stateNext = RD;
                    end
                end
            end
            RD:      stateNext = WR;
            WR:      stateNext = lastByte ? DONE : RD;
            FILL:    stateNext = lastByte ? DONE : FILL;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Parameter latch, index, read hold and checksum
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            srcReg      <= '0;
            dstReg      <= '0;
            lenReg      <= '0;
            fillReg     <= '0;
            idx         <= '0;
            holdReg     <= '0;
            checksumReg <= '0;
        end else if (startAccept) begin
            srcReg      <= SrcAddr;
            dstReg      <= DstAddr;
            lenReg      <= Len;
            fillReg     <= FillVal;
            idx         <= '0;
            checksumReg <= '0;
        end else begin
            case (state)
                RD: holdReg <= MemRdData;
                WR: begin
                    idx         <= idxNext;
                    checksumReg <= checksumReg + holdReg;
                end
                FILL: begin
                    idx         <= idxNext;
                    checksumReg <= checksumReg + fillReg;
                end
                default: ;
            endcase
        end
    end

    // Outputs: purely a function of state so reset clears them immediately.
    always_comb begin
        Busy      = 1'b0;
        Done      = 1'b0;
        MemAddr   = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemWrData = '0;
        case (state)
            RD: begin
                Busy    = 1'b1;
                MemRead = 1'b1;
                MemAddr = srcReg + idx;
            end
            WR: begin
                Busy      = 1'b1;
                MemWrite  = 1'b1;
                MemAddr   = dstReg + idx;
                MemWrData = holdReg;
            end
            FILL: begin
                Busy      = 1'b1;
                MemWrite  = 1'b1;
                MemAddr   = dstReg + idx;
                MemWrData = fillReg;
            end
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

    assign Checksum = checksumReg;

endmodule
